fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer of the program-counter address and producer of the `fetch_unit_valid` advance pulse.
- Reads one instruction at a time from instruction memory over a req/ack handshake, buffers it, and hands it to decode over a valid/ready handshake.
- Holds fetch after any control-flow instruction until its writeback resolves, so the PC is never advanced past an unresolved jump or branch.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INSN_W, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc_addr  in  ADDR_W  current PC; word-aligned by the PC block.
- fetch_unit_valid  out  1  one-cycle pulse; the PC advances by 4 on the same edge.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  read data valid, completes the request.
- mem_rdata  in  INSN_W  read data.
- out_valid  out  1  buffered instruction valid to decode.
- out_ready  in  1  decode accepts.
- out_insn  out  INSN_W  buffered instruction.
- out_pc  out  ADDR_W  address the instruction was fetched from.
- wb_valid  in  1  ALU-WB stage valid.
- wb_jmp_op  in  2  0 none, 1 unconditional, 2 conditional.
- wb_cmp  in  1  branch condition for jmp_op=2.
- wb_fault  in  1  fault at WB; the PC resets to 0.

Behaviour:
- **States:** FETCH, HOLD, WAIT_WB, ADVANCE, DRAIN. Reset → FETCH; out_valid=0, fetch_unit_valid=0, out_insn=0, out_pc=0.
- **Control-flow detection:** ctrl = out_insn[6:0] ∈ {1101111 JAL, 1100111 JALR, 1100011 BRANCH}.
- **FETCH:**
  - mem_req=1, mem_addr=pc_addr (combinational).
  - On mem_ack: out_insn←mem_rdata, out_pc←pc_addr, out_valid←1, go to HOLD.
  - Ack is allowed in the first FETCH cycle, giving a minimum of 1 cycle from request to out_valid.
- **HOLD:**
  - out_valid=1; out_insn and out_pc are held stable until out_ready.
  - On out_valid&&out_ready:
    - non-ctrl: fetch_unit_valid=1 in this same cycle (combinational), out_valid←0, go to FETCH. The next cycle sees pc_addr+4.
    - ctrl: fetch_unit_valid=0, out_valid←0, go to WAIT_WB.
- **WAIT_WB:**
  - mem_req=0; the PC holds.
  - On wb_valid&&!wb_fault&&wb_jmp_op≠0:
    - taken (jmp_op=1, or jmp_op=2&&wb_cmp): go to FETCH. The PC has loaded the target on the same edge.
    - not taken (jmp_op=2&&!wb_cmp): go to ADVANCE.
  - wb_valid with jmp_op=0 (older instruction draining) is ignored.
- **ADVANCE:** fetch_unit_valid=1 for exactly one cycle, then go to FETCH; the PC moves past the branch.
- **Fault:** wb_valid&&wb_fault overrides everything, in any state:
  - out_valid←0, fetch_unit_valid=0 that cycle.
  - From FETCH without mem_ack that cycle: capture drain_addr←pc_addr, go to DRAIN.
  - From FETCH with mem_ack that cycle: discard the data, go to FETCH.
  - From all other states: go to FETCH.
- **DRAIN:** mem_req=1, mem_addr=drain_addr, held until mem_ack; the data is discarded, then go to FETCH (the PC is now 0).
- **Memory rule:** mem_req is never withdrawn before mem_ack; at most one request is outstanding.
- **Outputs driven only in states:** fetch_unit_valid only in HOLD (accept, non-ctrl) or ADVANCE; mem_req only in FETCH/DRAIN.
- **rst:** in any state, including mid-request, returns to FETCH with out_valid=0. Memory shares rst, so there is no drain on reset.

Test Plan:
- **Straight-line fetch:** memory holds addi at 0,4,8; ack latency 1; out_ready=1 → out_pc 0,4,8 in order, one fetch_unit_valid pulse per accept, out_insn matches memory.
- **Decode backpressure:** out_ready=0 for 5 cycles at pc=4 → out_valid stays 1, out_insn/out_pc stable, no fetch_unit_valid and no mem_req until accept.
- **Taken JAL:** 0x0080006F at pc=8 → out_valid after JAL drops and no fetch until WB; WB jmp_op=1 with the PC moved to 0x10 → next mem_addr=0x10, no pulse for 8.
- **Branch not taken:** BEQ at pc=0xC, WB jmp_op=2 with cmp=0 → exactly one ADVANCE pulse, next mem_addr=0x10, the branch is not re-fetched.
- **Fault mid-request:** memory ack latency 4, wb_fault asserted in the 2nd FETCH cycle at pc=0x20 → mem_req stays high with mem_addr=0x20 until ack, data dropped, then fetch from 0.
- **Fault in HOLD and reset mid-FETCH:** fault in HOLD → out_valid cleared the next cycle, refetch from 0; rst during FETCH → out_valid=0 and mem_req re-asserted on the first post-reset cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetches one instruction at a time from instruction memory over a req/ack
// handshake and buffers it for decode, which takes it over a valid/ready
// handshake. The PC block lives outside this unit. It advances by 4 on every
// fetch_unit_valid pulse, loads a jump target when writeback resolves a taken
// jump, and returns to 0 on a writeback fault.
//
// After a control-flow instruction (JAL, JALR, BRANCH) is handed to decode,
// fetch stalls until writeback resolves it. This keeps the PC from ever
// advancing past an unresolved jump.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pc_addr           current PC (word aligned)
//   fetch_unit_valid  one-cycle pulse; the PC advances by 4 on this edge
//   mem_req/mem_addr  instruction read request and address
//   mem_ack/mem_rdata read completion and data
//   out_valid/out_ready/out_insn/out_pc  buffered instruction to decode
//   wb_valid/wb_jmp_op/wb_cmp/wb_fault   writeback resolution and fault
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int INSN_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              fetch_unit_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INSN_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              wb_valid,
    input  logic [1:0]        wb_jmp_op,
    input  logic              wb_cmp,
    input  logic              wb_fault
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_HOLD    = 3'd1,
        ST_WAIT_WB = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t            state_r;
    logic              out_valid_r;
    logic [INSN_W-1:0] out_insn_r;
    logic [ADDR_W-1:0] out_pc_r;
    logic [ADDR_W-1:0] drain_addr_r;

    logic fault_s;
    logic accept_s;
    logic ctrl_s;
    logic resolve_s;
    logic taken_s;
    logic not_taken_s;

    // JAL, JALR and conditional branches change control flow
    function automatic logic is_ctrl_f(input logic [6:0] opcode);
        logic res;
        case (opcode)
            7'b1101111: res = 1'b1;
            7'b1100111: res = 1'b1;
            7'b1100011: res = 1'b1;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

    // Decode of handshake and writeback events for the current cycle
    always_comb begin
        fault_s     = wb_valid && wb_fault;
        accept_s    = (state_r == ST_HOLD) && out_valid_r && out_ready;
        ctrl_s      = is_ctrl_f(out_insn_r[6:0]);
        // jmp_op == 0 is an older instruction draining and does not resolve anything
        resolve_s   = wb_valid && !wb_fault && (wb_jmp_op != 2'd0);
        taken_s     = resolve_s && ((wb_jmp_op == 2'd1) || ((wb_jmp_op == 2'd2) && wb_cmp));
        not_taken_s = resolve_s && (wb_jmp_op == 2'd2) && !wb_cmp;
    end

    // Memory request and PC-advance pulse, decoded from the current state
    always_comb begin
        mem_req          = 1'b0;
        mem_addr         = pc_addr;
        fetch_unit_valid = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_addr;
            end
            ST_DRAIN: begin
                // The PC has already moved to 0, so the abandoned address is replayed
                mem_req  = 1'b1;
                mem_addr = drain_addr_r;
            end
            ST_HOLD: begin
                fetch_unit_valid = accept_s && !ctrl_s && !fault_s;
            end
            ST_ADVANCE: begin
                fetch_unit_valid = !fault_s;
            end
            default: begin
                fetch_unit_valid = 1'b0;
            end
        endcase
    end

    // Fetch state machine with the decode-side instruction buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            out_valid_r  <= 1'b0;
            out_insn_r   <= {INSN_W{1'b0}};
            out_pc_r     <= {ADDR_W{1'b0}};
            drain_addr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (fault_s) begin
                        out_valid_r <= 1'b0;
                        if (mem_ack) begin
                            // Data arriving with the fault is dropped
                            state_r <= ST_FETCH;
                        end else begin
                            // The request is still open and must be completed
                            drain_addr_r <= pc_addr;
                            state_r      <= ST_DRAIN;
                        end
                    end else if (mem_ack) begin
                        out_insn_r  <= mem_rdata;
                        out_pc_r    <= pc_addr;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fault_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_FETCH;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ctrl_s ? ST_WAIT_WB : ST_FETCH;
                    end
                end
                ST_WAIT_WB: begin
                    if (fault_s || taken_s) begin
                        state_r <= ST_FETCH;
                    end else if (not_taken_s) begin
                        state_r <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_FETCH;
                end
                ST_DRAIN: begin
                    // A fault here does not abandon the drain; memory must see its ack
                    out_valid_r <= 1'b0;
                    if (mem_ack) begin
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_FETCH;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_insn  = out_insn_r;
    assign out_pc    = out_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// The environment contains the PC block, an instruction memory with variable
// ack latency, decode backpressure and a writeback driver. A transaction-level
// reference tracks three things: which address must be fetched next, what
// must be buffered for decode, and when the PC must advance. It follows the
// fetch rules: +4 after a plain instruction, the target after a taken jump,
// +4 after a not-taken branch, and 0 after a fault.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic        fetch_unit_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        wb_valid;
    logic [1:0]  wb_jmp_op;
    logic        wb_cmp;
    logic        wb_fault;

    fetch_unit #(.ADDR_W(32), .INSN_W(32)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .fetch_unit_valid(fetch_unit_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_jmp_op(wb_jmp_op), .wb_cmp(wb_cmp), .wb_fault(wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_ctrl(input logic [31:0] insn);
        logic [6:0] op;
        op = insn[6:0];
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
    endfunction

    function automatic logic [31:0] addi(input int i);
        logic [11:0] imm;
        imm = 12'(i);
        return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    // environment: program memory and knobs
    logic [31:0] mem [0:63];
    int          lat_min, lat_max, ready_pct, fault_pm, noise_pct, wb_dly_max;
    logic        tgt_fixed_en, cmp_force_en, cmp_force;
    logic [31:0] tgt_fixed, hold_pc;
    int          hold_n, hold_seen;
    int          trig_kind;      // 0 none, 1 fault 2nd req cycle, 2 fault in hold, 3 reset 2nd req cycle
    logic [31:0] trig_pc;
    logic        trig_done;

    // environment state and reference
    logic [31:0] pc_m;
    logic        mem_busy, mem_discard;
    logic [31:0] mem_q;
    int          mem_age, mem_lat;
    logic        exp_ov;
    logic [31:0] exp_insn, exp_pc, exp_next, ctrl_pc;
    logic        wait_wb, adv_due, post_rst;
    logic [1:0]  ctrl_kind;
    int          wb_cnt, pulse_cnt;
    logic [31:0] acc_q [$];

    task automatic reset_env();
        pc_m = 32'd0; mem_busy = 1'b0; mem_discard = 1'b0; mem_q = 32'd0;
        mem_age = 0; mem_lat = 1; exp_ov = 1'b0; exp_insn = 32'd0; exp_pc = 32'd0;
        exp_next = 32'd0; ctrl_pc = 32'd0; wait_wb = 1'b0; adv_due = 1'b0;
        ctrl_kind = 2'd0; wb_cnt = 0; pulse_cnt = 0;
        acc_q.delete();
    endtask

    task automatic tick(input logic do_rst);
        logic fault, taken, nt, ack, accept, exp_pulse, trig_hit;
        logic [31:0] tgt;
        int r;
        @(negedge clk);
        fault = 1'b0; taken = 1'b0; nt = 1'b0; ack = 1'b0;
        trig_hit = 1'b0;
        if (!trig_done) begin
            if ((trig_kind == 1 || trig_kind == 3) && mem_busy && !mem_discard &&
                mem_q == trig_pc && mem_age == 1)
                trig_hit = 1'b1;
            if (trig_kind == 2 && exp_ov && exp_pc == trig_pc)
                trig_hit = 1'b1;
        end
        pc_addr   = pc_m;
        wb_valid  = 1'b0; wb_jmp_op = 2'd0; wb_cmp = 1'b0; wb_fault = 1'b0;
        mem_ack   = 1'b0; mem_rdata = $urandom();
        r = $urandom_range(99, 0);
        out_ready = (r < ready_pct);
        if (do_rst || (trig_hit && trig_kind == 3)) begin
            if (trig_hit) trig_done = 1'b1;
            rst = 1'b1;
            #2;
            reset_env();
            post_rst = 1'b1;
            return;
        end
        rst = 1'b0;
        tgt = tgt_fixed_en ? tgt_fixed : {24'd0, 6'($urandom_range(63, 0)), 2'b00};
        r = $urandom_range(999, 0);
        if ((trig_hit && (trig_kind == 1 || trig_kind == 2)) || r < fault_pm) begin
            if (trig_hit) trig_done = 1'b1;
            fault = 1'b1;
            wb_valid = 1'b1; wb_fault = 1'b1; wb_jmp_op = 2'($urandom_range(3, 0));
        end else if (wait_wb && wb_cnt == 0) begin
            wb_valid  = 1'b1;
            wb_jmp_op = ctrl_kind;
            wb_cmp    = cmp_force_en ? cmp_force : 1'($urandom_range(1, 0));
            taken     = (ctrl_kind == 2'd1) || wb_cmp;
            nt        = (ctrl_kind == 2'd2) && !wb_cmp;
        end else if ($urandom_range(99, 0) < noise_pct) begin
            wb_valid = 1'b1; wb_jmp_op = 2'd0; wb_cmp = 1'($urandom_range(1, 0));
        end
        if (wait_wb && wb_cnt > 0) wb_cnt--;
        if (exp_ov && exp_pc == hold_pc && hold_seen < hold_n) begin
            out_ready = 1'b0;
            hold_seen++;
        end
        #1;
        // memory model
        if (mem_busy) chk("req_held", 32'(mem_req), 32'd1);
        if (mem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1; mem_q = mem_addr; mem_age = 0;
                mem_lat  = $urandom_range(lat_max, lat_min);
                chk("fetch_addr", mem_addr, exp_next);
            end else begin
                chk("addr_stable", mem_addr, mem_q);
            end
            ack = (mem_age == mem_lat - 1);
        end
        mem_ack = ack;
        if (ack) mem_rdata = mem[mem_q[7:2]];
        #1;
        // output checks against the reference
        if (post_rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_mem_req", 32'(mem_req), 32'd1);
            chk("rst_out_insn", out_insn, 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
            post_rst = 1'b0;
        end
        accept    = exp_ov && out_ready;
        exp_pulse = !fault && (adv_due || (accept && !is_ctrl(exp_insn)));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_insn", out_insn, exp_insn);
        end
        chk("pulse", 32'(fetch_unit_valid), 32'(exp_pulse));
        if (wait_wb || exp_ov || adv_due) chk("req_idle", 32'(mem_req), 32'd0);
        else chk("req_fetch", 32'(mem_req), 32'd1);
        if (fetch_unit_valid) pulse_cnt++;
        // advance the reference past this edge
        if (ack) begin
            mem_busy = 1'b0;
            if (!mem_discard && !fault) begin
                exp_ov = 1'b1; exp_insn = mem[mem_q[7:2]]; exp_pc = mem_q;
            end
            mem_discard = 1'b0;
        end else if (mem_busy) begin
            mem_age++;
            if (fault) mem_discard = 1'b1;
        end
        if (fault) begin
            exp_ov = 1'b0; wait_wb = 1'b0; adv_due = 1'b0; exp_next = 32'd0; pc_m = 32'd0;
        end else begin
            if (fetch_unit_valid) pc_m = pc_m + 32'd4;
            adv_due = 1'b0;
            if (accept) begin
                exp_ov = 1'b0;
                acc_q.push_back(out_pc);
                if (is_ctrl(exp_insn)) begin
                    wait_wb   = 1'b1;
                    ctrl_pc   = exp_pc;
                    ctrl_kind = (exp_insn[6:0] == 7'h63) ? 2'd2 : 2'd1;
                    wb_cnt    = $urandom_range(wb_dly_max, 0);
                end else begin
                    exp_next = exp_pc + 32'd4;
                end
            end
            if (taken) begin
                wait_wb = 1'b0; pc_m = tgt; exp_next = tgt;
            end
            if (nt) begin
                wait_wb = 1'b0; adv_due = 1'b1; exp_next = ctrl_pc + 32'd4;
            end
        end
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (!((acc_q.size() >= n) && (trig_kind == 0 || trig_done)) && c < budget) begin
            tick(1'b0);
            c++;
        end
        chk(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input int idx, input logic [31:0] exp);
        if (idx < acc_q.size()) chk(tag, acc_q[idx], exp);
        else chk(tag, 32'(acc_q.size()), 32'(idx + 1));
    endtask

    task automatic directed_setup(input int lmin, input int lmax);
        for (int i = 0; i < 64; i++) mem[i] = addi(i);
        lat_min = lmin; lat_max = lmax; ready_pct = 100; fault_pm = 0; noise_pct = 0;
        wb_dly_max = 1; tgt_fixed_en = 1'b0; tgt_fixed = 32'd0; cmp_force_en = 1'b0;
        cmp_force = 1'b0; hold_pc = 32'hFFFF_FFFF; hold_n = 0; hold_seen = 0;
        trig_kind = 0; trig_pc = 32'd0; trig_done = 1'b0;
        tick(1'b1);
        tick(1'b1);
    endtask

    initial begin
        rst = 1'b1; pc_addr = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_jmp_op = 2'd0; wb_cmp = 1'b0; wb_fault = 1'b0;
        post_rst = 1'b0;
        reset_env();

        // straight line, backpressure at 4, taken JAL at 8 to 0x10
        directed_setup(1, 1);
        mem[2] = 32'h0080006F;
        tgt_fixed_en = 1'b1; tgt_fixed = 32'h10;
        hold_pc = 32'd4; hold_n = 5;
        run_until("a_budget", 5, 300);
        chk_seq("a_seq0", 0, 32'h0);
        chk_seq("a_seq1", 1, 32'h4);
        chk_seq("a_seq2", 2, 32'h8);
        chk_seq("a_seq3", 3, 32'h10);
        chk_seq("a_seq4", 4, 32'h14);
        chk("a_hold", 32'(hold_seen), 32'd5);
        chk("a_pulses", 32'(pulse_cnt), 32'd4);

        // BEQ at 0xC not taken: one advance pulse, then 0x10
        directed_setup(1, 2);
        mem[3] = 32'h00000063;
        cmp_force_en = 1'b1; cmp_force = 1'b0; wb_dly_max = 3;
        run_until("b_budget", 6, 300);
        chk_seq("b_seq3", 3, 32'hC);
        chk_seq("b_seq4", 4, 32'h10);
        chk_seq("b_seq5", 5, 32'h14);
        chk("b_pulses", 32'(pulse_cnt), 32'd6);

        // fault in the 2nd cycle of the request at 0x20, ack latency 4
        directed_setup(4, 4);
        trig_kind = 1; trig_pc = 32'h20;
        run_until("c_budget", 10, 600);
        chk_seq("c_seq7", 7, 32'h1C);
        chk_seq("c_seq8", 8, 32'h0);
        chk_seq("c_seq9", 9, 32'h4);

        // fault while holding pc 8
        directed_setup(1, 1);
        trig_kind = 2; trig_pc = 32'h8;
        run_until("d_budget", 4, 300);
        chk_seq("d_seq2", 2, 32'h0);
        chk_seq("d_seq3", 3, 32'h4);

        // reset in the 2nd cycle of the request at 0x10
        directed_setup(4, 4);
        trig_kind = 3; trig_pc = 32'h10;
        run_until("e_budget", 3, 600);
        chk_seq("e_seq0", 0, 32'h0);
        chk_seq("e_seq2", 2, 32'h8);

        // randomized program, latency, backpressure, writeback and faults
        directed_setup(1, 4);
        for (int i = 0; i < 64; i++) begin
            int k;
            k = $urandom_range(9, 0);
            if (k < 6) mem[i] = addi($urandom_range(4095, 0));
            else if (k == 6) mem[i] = {$urandom_range(33554431, 0), 7'h6F};
            else if (k == 7) mem[i] = {$urandom_range(33554431, 0), 7'h67};
            else mem[i] = {$urandom_range(33554431, 0), 7'h63};
        end
        ready_pct = 70; fault_pm = 8; noise_pct = 10; wb_dly_max = 3;
        for (int c = 0; c < 4000; c++) tick(1'b0);
        chk("rand_progress", 32'(acc_q.size() > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
